// File: rtl/serial_sub_pkg.sv
// Shared types and geometry helpers for the digit-serial subtractor.
// Optional saturation is enabled in serial_sub by defining SERIAL_SUB_SAT_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of digit steps needed to cover the full operand width.
  function automatic int unsigned calc_steps(input int unsigned width,
                                             input int unsigned digit);
    return (digit == 0) ? 0 : width / digit;
  endfunction

  // Step counter width: $clog2(STEPS), never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned width,
                                             input int unsigned digit);
    int unsigned steps;
    steps = calc_steps(width, digit);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: diff = x - y - bi, bout = borrow out.
module sub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  always_comb begin
    logic br;
    diff = '0;
    br   = bi;
    for (int i = 0; i < DIGIT; i++) begin
      diff[i] = x[i] ^ y[i] ^ br;
      br      = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/serial_sub.sv
// Digit-serial N-bit subtractor d = a - b - bin with valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to clamp d to zero whenever the final borrow is set.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int unsigned STEPS = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(WIDTH, DIGIT);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_sub: DIGIT (%0d) must divide WIDTH (%0d) exactly", DIGIT, WIDTH);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             bo_q, bo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT-1:0] diff;
  logic             bout;
  logic             last_step;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .bi   (borrow_q),
    .diff (diff),
    .bout (bout)
  );

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bo        = bo_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
        end
      end

      RUN: begin
        // Result digits enter at the top, so the first (LSB) digit ends at bit 0.
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        d_d      = WIDTH'({diff, d_q} >> DIGIT);
        borrow_d = bout;
        if (last_step) begin
          state_d = DONE;
          bo_d    = bout;
`ifdef SERIAL_SUB_SAT_EN
          if (bout) begin
            d_d = '0;
          end
`else
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge values.
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so an aborted run leaves no residue.
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Multi-cycle, parametrised N-bit subtractor computing d = a − b − bin with borrow-out bo. It processes DIGIT bits per cycle through a borrow chain held in a register, and uses valid/ready handshakes on both sides. It is the sequential, width-generic successor to the single-bit half subtractor, for datapaths where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 1.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly, otherwise elaboration fails.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands a, b and bin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  d and bo are valid.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference.
- bo  output  1  borrow-out from the MSB; 1 means a < b + bin.

## Operation
- STEPS = WIDTH/DIGIT.
- FSM states:
  - IDLE → RUN on in_valid && in_ready. Latch a, b and bin into shift registers. Clear the step counter.
  - RUN: each cycle, subtract the lowest DIGIT bits of the a and b registers with the current borrow. Shift the result digit into the top of the d register. Update the borrow register. Increment the counter. After step STEPS−1 completes, go to DONE.
  - DONE: out_valid = 1. d and bo are held stable. On out_ready, go to IDLE.
- Arithmetic: d = (a − b − bin) mod 2^WIDTH. bo = borrow out of bit WIDTH−1. Operands are unsigned.
- Behaviour outside IDLE:
  - in_valid is ignored; no queuing.
  - a, b and bin may change freely after acceptance.
- out_ready while out_valid = 0 has no effect.
- d and bo must not change while out_valid = 1.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, d = 0, bo = 0, counter = 0, internal registers = 0.
- Latency: operands accepted at edge k produce out_valid = 1 from edge k+STEPS.
- Handshake in DONE:
  - With out_ready held high, state is IDLE after edge k+STEPS+1.
  - in_ready is high in that cycle.
  - Minimum issue interval is STEPS+2 cycles.
- Backpressure: DONE persists indefinitely while out_ready = 0.
- Reset mid-operation (rst_n low at any edge):
  - Abort immediately; all registers return to their reset values at that edge.
  - No partial result is ever presented.
- Counter width is $clog2(STEPS) bits, minimum 1. The counter does not wrap inside an operation.
- DIGIT = WIDTH gives single-step operation: STEPS = 1, latency 1.

## Configuration
- SERIAL_SUB_SAT_EN defined:
  - When the final bo = 1, the presented d is forced to 0, saturating at zero.
  - bo is still reported as 1.
  - Saturation is applied at the RUN→DONE transition, so latency is unchanged.
- SERIAL_SUB_SAT_EN undefined: d is the modular result as defined in Operation; no saturation logic is present.

## Structure
- Shared package serial_sub_pkg holds:
  - the FSM state enum: IDLE, RUN, DONE;
  - a function computing STEPS and the counter width from WIDTH and DIGIT.
- Sub-module sub_digit: a combinational DIGIT-bit ripple subtractor.
  - Inputs: x[DIGIT], y[DIGIT], bi.
  - Outputs: diff[DIGIT], bout.
  - Instantiated once; the top level holds the FSM, counter and shift registers.
- The parameter legality check (DIGIT divides WIDTH) is done in the top level at elaboration.

## Test plan
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 → out_valid exactly 8 cycles after acceptance; d=0x02, bo=0.
- WIDTH=8, DIGIT=1: a=0x03, b=0x05, bin=0 → d=0xFE, bo=1. With SERIAL_SUB_SAT_EN: d=0x00, bo=1.
- WIDTH=8, DIGIT=4: a=0x00, b=0x00, bin=1 → latency 2; d=0xFF, bo=1. Then a=0xFF, b=0xFF, bin=0 → d=0x00, bo=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → d and bo stable, in_ready=0 throughout. out_ready=1 → next cycle in_ready=1.
- Protocol checks:
  - Pulse in_valid with new operands during RUN → ignored; the original result is delivered.
  - Assert rst_n=0 for one edge at RUN step 3 → out_valid=0, in_ready=1, d=0, bo=0 after that edge.
  - A fresh operation afterwards completes correctly.
- Randomised sweep: exhaustive for WIDTH=4 over DIGIT ∈ {1, 2, 4} → every result matches (a − b − bin) mod 16 and the expected borrow.
